// File: rtl/cpu_pkg.sv
// Shared pipeline constants for the five-stage core: operand use-time encoding,
// default multiply/divide latencies and the MDU busy-tracker state encoding.
package cpu_pkg;

    // A use-time of 3 marks an operand the ID instruction does not read.
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/md_busy_tracker.sv
// Tracks the multi-cycle multiply/divide unit: a two-state FSM plus a down-counter
// of remaining busy cycles, armed when a mult/div instruction leaves EX.
module md_busy_tracker
    import cpu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       md_start,
    input  logic       md_div,
    output md_state_t  state,
    output logic [3:0] md_count
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    md_state_t  state_q;
    logic [3:0] count_q;
    logic [3:0] load_val;

    assign load_val = md_div ? DIV_LOAD : MULT_LOAD;

    // A start while already busy restarts the window; ID normally prevents this.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            count_q <= 4'd0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (md_start) begin
                        state_q <= MD_BUSY;
                        count_q <= load_val;
                    end
                end
                MD_BUSY: begin
                    if (md_start) begin
                        count_q <= load_val;
                    end else if (count_q == 4'd1) begin
                        state_q <= MD_IDLE;
                        count_q <= 4'd0;
                    end else begin
                        count_q <= count_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= MD_IDLE;
                    count_q <= 4'd0;
                end
            endcase
        end
    end

    assign state    = state_q;
    assign md_count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/bubble controller: compares ID operands against EX/MEM destinations using
// Tuse/Tnew, adds MDU-busy hazards, and drives PC/IF-ID enables and the ID/EX flush.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [1:0]  id_tuse_rs,
    input  logic [1:0]  id_tuse_rt,
    input  logic        id_md_use,
    input  logic [4:0]  ex_wreg,
    input  logic [1:0]  ex_tnew,
    input  logic [4:0]  mem_wreg,
    input  logic [1:0]  mem_tnew,
    input  logic        ex_md_start,
    input  logic        ex_md_div,
    output logic        stall,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_flush,
    output logic        md_busy,
    output logic [3:0]  md_count,
    output logic [31:0] stall_cnt
);

    md_state_t   md_state;
    logic        rs_hazard;
    logic        rt_hazard;
    logic        md_hazard;
    logic        hazard;
    logic [31:0] stall_cnt_q;

    md_busy_tracker #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_tracker (
        .clk      (clk),
        .reset    (reset),
        .md_start (ex_md_start),
        .md_div   (ex_md_div),
        .state    (md_state),
        .md_count (md_count)
    );

    assign md_busy = (md_state == MD_BUSY);

    // An operand stalls only if a producer's result is not forwardable in time.
    // The TUSE_NONE term is implied by Tnew <= 2 but keeps the intent explicit.
    assign rs_hazard = (id_rs != 5'd0) && (id_tuse_rs != TUSE_NONE) &&
                       (((id_rs == ex_wreg)  && (ex_tnew  > id_tuse_rs)) ||
                        ((id_rs == mem_wreg) && (mem_tnew > id_tuse_rs)));

    assign rt_hazard = (id_rt != 5'd0) && (id_tuse_rt != TUSE_NONE) &&
                       (((id_rt == ex_wreg)  && (ex_tnew  > id_tuse_rt)) ||
                        ((id_rt == mem_wreg) && (mem_tnew > id_tuse_rt)));

    assign md_hazard = id_md_use && (md_busy || ex_md_start);

    assign hazard      = rs_hazard || rt_hazard || md_hazard;
    assign stall       = hazard && !reset;
    assign pc_en       = !stall;
    assign if_id_en    = !stall;
    assign id_ex_flush = stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a table of register-hazard vectors plus
// hand-written multiply, divide, reset-abort and counter-saturation sequences.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt;
    logic [1:0]  id_tuse_rs, id_tuse_rt;
    logic        id_md_use;
    logic [4:0]  ex_wreg, mem_wreg;
    logic [1:0]  ex_tnew, mem_tnew;
    logic        ex_md_start, ex_md_div;
    logic        stall, pc_en, if_id_en, id_ex_flush, md_busy;
    logic [3:0]  md_count;
    logic [31:0] stall_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] exp_cnt;
    logic [3:0]  exp_q[$];

    hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_tuse_rs  (id_tuse_rs),
        .id_tuse_rt  (id_tuse_rt),
        .id_md_use   (id_md_use),
        .ex_wreg     (ex_wreg),
        .ex_tnew     (ex_tnew),
        .mem_wreg    (mem_wreg),
        .mem_tnew    (mem_tnew),
        .ex_md_start (ex_md_start),
        .ex_md_div   (ex_md_div),
        .stall       (stall),
        .pc_en       (pc_en),
        .if_id_en    (if_id_en),
        .id_ex_flush (id_ex_flush),
        .md_busy     (md_busy),
        .md_count    (md_count),
        .stall_cnt   (stall_cnt)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tuse_rs;
        logic [1:0] tuse_rt;
        logic       md_use;
        logic [4:0] ex_wreg;
        logic [1:0] ex_tnew;
        logic [4:0] mem_wreg;
        logic [1:0] mem_tnew;
        logic       exp_stall;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_stall(input string name, input logic exp_s);
        check({name, ".stall"}, {31'd0, stall}, {31'd0, exp_s});
        check({name, ".pc_en"}, {31'd0, pc_en}, {31'd0, !exp_s});
        check({name, ".if_id_en"}, {31'd0, if_id_en}, {31'd0, !exp_s});
        check({name, ".flush"}, {31'd0, id_ex_flush}, {31'd0, exp_s});
    endtask

    // Driver tasks: inputs change on the falling edge, outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0;
        id_tuse_rs = 2'd3; id_tuse_rt = 2'd3;
        id_md_use = 1'b0;
        ex_wreg = 5'd0; ex_tnew = 2'd0;
        mem_wreg = 5'd0; mem_tnew = 2'd0;
        ex_md_start = 1'b0; ex_md_div = 1'b0;
    endtask

    task automatic load_use();
        id_rs = 5'd8; id_tuse_rs = 2'd1;
        ex_wreg = 5'd8; ex_tnew = 2'd2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_cnt = 32'd0;
    endtask

    initial begin
        vecs[0] = '{"load_use_ex",  5'd8,  5'd0, 2'd1, 2'd3, 1'b0, 5'd8,  2'd2, 5'd0,  2'd0, 1'b1};
        vecs[1] = '{"mem_tnew_ok",  5'd8,  5'd0, 2'd1, 2'd3, 1'b0, 5'd0,  2'd0, 5'd8,  2'd1, 1'b0};
        vecs[2] = '{"reg_zero",     5'd0,  5'd0, 2'd0, 2'd3, 1'b0, 5'd0,  2'd2, 5'd0,  2'd2, 1'b0};
        vecs[3] = '{"rt_unused",    5'd0,  5'd9, 2'd3, 2'd3, 1'b0, 5'd9,  2'd2, 5'd0,  2'd0, 1'b0};
        vecs[4] = '{"rt_mem",       5'd0,  5'd9, 2'd3, 2'd0, 1'b0, 5'd0,  2'd0, 5'd9,  2'd1, 1'b1};
        vecs[5] = '{"rs_ex_tuse0",  5'd5,  5'd0, 2'd0, 2'd3, 1'b0, 5'd5,  2'd1, 5'd0,  2'd0, 1'b1};
        vecs[6] = '{"rs_ex_tuse2",  5'd5,  5'd0, 2'd2, 2'd3, 1'b0, 5'd5,  2'd2, 5'd0,  2'd0, 1'b0};
        vecs[7] = '{"rt_mem31",     5'd0,  5'd31, 2'd3, 2'd1, 1'b0, 5'd0, 2'd0, 5'd31, 2'd2, 1'b1};
        vecs[8] = '{"no_match",     5'd3,  5'd4, 2'd0, 2'd0, 1'b0, 5'd7,  2'd2, 5'd6,  2'd2, 1'b0};
        vecs[9] = '{"md_use_idle",  5'd0,  5'd0, 2'd3, 2'd3, 1'b1, 5'd0,  2'd0, 5'd0,  2'd0, 1'b0};

        idle_inputs();
        // Reset holds outputs inactive even with a hazard present
        reset = 1'b1;
        load_use();
        id_md_use = 1'b1; ex_md_start = 1'b1;
        @(negedge clk);
        #1 check_stall("in_reset", 1'b0);
        tick();
        reset = 1'b0;
        idle_inputs();
        exp_cnt = 32'd0;
        #1;
        check("rst.md_busy", {31'd0, md_busy}, 32'd0);
        check("rst.md_count", {28'd0, md_count}, 32'd0);
        check("rst.stall_cnt", stall_cnt, 32'd0);
        @(negedge clk);

        // Table-driven register-hazard vectors
        for (int i = 0; i < 10; i++) begin
            id_rs = vecs[i].rs; id_rt = vecs[i].rt;
            id_tuse_rs = vecs[i].tuse_rs; id_tuse_rt = vecs[i].tuse_rt;
            id_md_use = vecs[i].md_use;
            ex_wreg = vecs[i].ex_wreg; ex_tnew = vecs[i].ex_tnew;
            mem_wreg = vecs[i].mem_wreg; mem_tnew = vecs[i].mem_tnew;
            #1 check_stall(vecs[i].name, vecs[i].exp_stall);
            if (vecs[i].exp_stall) exp_cnt++;
            tick();
        end
        idle_inputs();
        #1 check("table.stall_cnt", stall_cnt, exp_cnt);
        @(negedge clk);

        // Multiply window with an MDU instruction waiting in ID
        id_md_use = 1'b1; ex_md_start = 1'b1; ex_md_div = 1'b0;
        #1 check_stall("mult_t", 1'b1);
        exp_cnt++;
        for (int k = 5; k >= 1; k--) exp_q.push_back(4'(k));
        tick();
        ex_md_start = 1'b0;
        while (exp_q.size() > 0) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            #1;
            check("mult.md_count", {28'd0, md_count}, {28'd0, e});
            check("mult.md_busy", {31'd0, md_busy}, 32'd1);
            check("mult.stall", {31'd0, stall}, 32'd1);
            exp_cnt++;
            tick();
        end
        #1;
        check("mult_end.md_busy", {31'd0, md_busy}, 32'd0);
        check("mult_end.stall", {31'd0, stall}, 32'd0);
        check("mult_end.stall_cnt", stall_cnt, exp_cnt);
        @(negedge clk);

        // Divide window: non-MDU instruction flows through
        begin
            int busy_cycles;
            busy_cycles = 0;
            idle_inputs();
            ex_md_start = 1'b1; ex_md_div = 1'b1;
            #1 check("div_t.stall", {31'd0, stall}, 32'd0);
            tick();
            ex_md_start = 1'b0;
            #1 check("div.first_count", {28'd0, md_count}, 32'd10);
            for (int c = 0; c < 15; c++) begin
                if (md_busy) busy_cycles++;
                if (stall) check("div.non_md_stall", {31'd0, stall}, 32'd0);
                tick();
                #1;
            end
            check("div.busy_cycles", busy_cycles, 32'd10);
            check("div.stall_cnt", stall_cnt, exp_cnt);
            @(negedge clk);
        end

        // Reset in the middle of a divide
        begin
            int guard;
            ex_md_start = 1'b1; ex_md_div = 1'b1;
            tick();
            ex_md_start = 1'b0;
            guard = 0;
            while (md_count != 4'd6 && guard < 12) begin
                tick();
                guard++;
            end
            check("rdiv.reach6", {28'd0, md_count}, 32'd6);
            reset = 1'b1;
            load_use();
            id_md_use = 1'b1;
            #1 check_stall("rdiv.in_reset", 1'b0);
            tick();
            reset = 1'b0;
            idle_inputs();
            exp_cnt = 32'd0;
            #1;
            check("rdiv.md_busy", {31'd0, md_busy}, 32'd0);
            check("rdiv.md_count", {28'd0, md_count}, 32'd0);
            check("rdiv.stall_cnt", stall_cnt, 32'd0);
            @(negedge clk);
        end

        // Seven forced stall cycles
        load_use();
        for (int c = 0; c < 7; c++) tick();
        idle_inputs();
        exp_cnt = 32'd7;
        #1 check("cnt7.stall_cnt", stall_cnt, exp_cnt);
        @(negedge clk);

        // Register and MDU hazard together count once
        load_use();
        id_md_use = 1'b1; ex_md_start = 1'b1; ex_md_div = 1'b0;
        #1 check_stall("both", 1'b1);
        tick();
        idle_inputs();
        exp_cnt++;
        #1 check("both.stall_cnt", stall_cnt, exp_cnt);
        for (int c = 0; c < 6; c++) tick();

        // Saturation near the top of the counter
        do_reset();
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        tick();
        release dut.stall_cnt_q;
        #1 check("sat.preload", stall_cnt, 32'hFFFF_FFFE);
        @(negedge clk);
        load_use();
        tick();
        #1 check("sat.to_max", stall_cnt, 32'hFFFF_FFFF);
        @(negedge clk);
        tick();
        #1 check("sat.hold", stall_cnt, 32'hFFFF_FFFF);
        idle_inputs();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Stall/bubble controller for the five-stage pipeline. Compares the ID-stage instruction's source registers and use-times against the destinations and new-times of the instructions in EX and MEM. It also tracks the multi-cycle multiply/divide unit with an internal busy FSM. From these it drives the PC and IF/ID write enables and the ID/EX flush that inserts a nop bubble. A saturating stall counter supports performance debug.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu leaves EX
- DIV_CYCLES, 10, busy cycles after a div/divu leaves EX

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high; clock clk
- id_rs  in  5  ID-stage rs address
- id_rt  in  5  ID-stage rt address
- id_tuse_rs  in  2  cycles until ID needs rs (0..2); 3 = rs not read
- id_tuse_rt  in  2  same for rt
- id_md_use  in  1  ID instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- ex_wreg  in  5  EX destination register (0 = none)
- ex_tnew  in  2  cycles until EX result is forwardable
- mem_wreg  in  5  MEM destination register (0 = none)
- mem_tnew  in  2  cycles until MEM result is forwardable
- ex_md_start  in  1  EX holds a mult/multu/div/divu this cycle
- ex_md_div  in  1  qualifies ex_md_start: 1 = divide, 0 = multiply
- stall  out  1  hazard detected this cycle
- pc_en  out  1  PC write enable, equals ~stall
- if_id_en  out  1  IF/ID write enable, equals ~stall
- id_ex_flush  out  1  OR'd into ID/EX reset: loads instruction 0 (nop), equals stall
- md_busy  out  1  MDU busy state
- md_count  out  4  remaining MDU busy cycles
- stall_cnt  out  32  total stalled cycles since reset, saturating

## Operation
- Register hazard on rs: id_rs != 0, and one of:
  - id_rs == ex_wreg and ex_tnew > id_tuse_rs
  - id_rs == mem_wreg and mem_tnew > id_tuse_rs
- Register hazard on rt: same rule using id_rt and id_tuse_rt.
- Use-time 3 never stalls because no Tnew exceeds 2. Register 0 never stalls.
- MDU hazard: id_md_use and (md_busy or ex_md_start).
- stall = rs hazard | rt hazard | MDU hazard. It is combinational from the inputs and current state.
- MDU FSM, states IDLE and BUSY:
  - IDLE, ex_md_start=1: go to BUSY; md_count loads DIV_CYCLES if ex_md_div, else MULT_CYCLES.
  - BUSY: md_count decrements each cycle; at md_count == 1, go to IDLE with md_count = 0.
  - BUSY, ex_md_start=1: illegal in normal flow, since ID stalls. The FSM restarts: md_count reloads and the state stays BUSY.
- md_busy = (state == BUSY).
- stall_cnt increments on every cycle with stall=1. It holds at 0xFFFFFFFF.

## Timing
- Reset values: FSM IDLE, md_busy 0, md_count 0, stall_cnt 0.
- While reset=1: stall 0, pc_en 1, if_id_en 1, id_ex_flush 0, regardless of inputs.
- Reset mid-operation aborts the MDU busy window immediately, on the next edge.
- Stall decision has zero latency, in the same cycle as the inputs. It repeats every cycle until the hazard clears, because the bubble advances the EX/MEM Tnew values.
- Multiply window: if ex_md_start is high in cycle t, then md_busy is 1 in cycles t+1..t+MULT_CYCLES, and an MDU instruction in ID is released in cycle t+MULT_CYCLES+1.
- An MDU instruction in ID is also stalled in cycle t itself, because ex_md_start=1.
- Simultaneous register and MDU hazards produce a single stall. stall_cnt increments once.
- The counter saturates with no wrap-around.

## Structure
- Shared package cpu_pkg holds:
  - TUSE_NONE = 2'd3
  - MULT_CYCLES_DEF and DIV_CYCLES_DEF
  - the MDU state enum
- One natural sub-module, md_busy_tracker: the MDU FSM plus md_count.
- hazard_ctrl instantiates md_busy_tracker and contains the comparison logic and stall_cnt.

## Test plan
- Load-use: ex_wreg=8, ex_tnew=2, id_rs=8, id_tuse_rs=1 -> stall=1, pc_en=0, id_ex_flush=1.
  - Next cycle mem_wreg=8, mem_tnew=1, ex_wreg=0 -> stall=0.
- Register 0 and unused operand: id_rs=0 with ex_wreg=0, ex_tnew=2 -> stall=0. id_rt=9, id_tuse_rt=3, ex_wreg=9, ex_tnew=2 -> stall=0.
- Multiply: ex_md_start=1, ex_md_div=0 at cycle t, id_md_use held 1 -> md_count=5,4,3,2,1 in cycles t+1..t+5 and stall=1 in cycles t..t+5. At t+6: md_busy=0, stall=0.
- Divide: ex_md_div=1 -> md_busy high for exactly 10 cycles. A non-MDU instruction in ID (id_md_use=0) during the window -> stall=0.
- Reset mid-divide: assert reset when md_count=6 -> next cycle md_busy=0, md_count=0, stall_cnt=0. During reset: pc_en=1, id_ex_flush=0.
- Counter: force 7 stall cycles -> stall_cnt=7. Preloaded (forced) to 0xFFFFFFFF plus one more stall cycle -> stall_cnt stays 0xFFFFFFFF.
